// File: rtl/memory_bus_bridge_pkg.sv
// memory_bus_bridge_pkg: funct3 option codes, bridge FSM states and load lane shift shared by the bridge files
package memory_bus_bridge_pkg;
  localparam logic [2:0] OPT_B = 3'b000;
  localparam logic [2:0] OPT_H = 3'b001;
  localparam logic [2:0] OPT_W = 3'b010;
  localparam logic [2:0] OPT_BU = 3'b100;
  localparam logic [2:0] OPT_HU = 3'b101;
  localparam int LANE_SHIFT = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;
endpackage

// File: rtl/memory_bus_bridge_load_formatter.sv
// memory_bus_bridge_load_formatter: extracts the addressed lane of a slave word and sign/zero-extends it (in: rdata, offset, option; out: data)
module memory_bus_bridge_load_formatter
  import memory_bus_bridge_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  option,
  output logic [31:0] data
);
  logic [31:0] lane;
  assign lane = rdata >> ({3'b000, offset} * 5'(LANE_SHIFT));
  assign data = option == OPT_B  ? {{24{lane[7]}}, lane[7:0]} :
                option == OPT_BU ? {24'b0, lane[7:0]} :
                option == OPT_H  ? {{16{lane[15]}}, lane[15:0]} :
                option == OPT_HU ? {16'b0, lane[15:0]} : lane;
endmodule

// File: rtl/memory_bus_bridge.sv
// memory_bus_bridge: core request (core_*) to word-aligned slave transaction (mem_*) bridge with load formatting, timeout and sticky bus_error/error_address
module memory_bus_bridge
  import memory_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [2:0]  core_option,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  output logic [31:0] core_read_data,
  output logic        core_response,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error,
  output logic [31:0] error_address
);
  state_t state_q, state_d;
  logic [COUNTER_WIDTH-1:0] count_q;
  logic [31:0] addr_q, data_q, rdata_q, fmt;
  logic [2:0] opt_q;
  logic we_q, err_q, start, illegal, timeout, issue, fail;
  assign start = core_read | core_write;
  assign illegal = core_option inside {3'b011, 3'b110, 3'b111} ||
                   (core_option[1:0] == OPT_H[1:0] && core_address[0]) ||
                   (core_option == OPT_W && core_address[1:0] != 2'b00) ||
                   (core_write && core_option[2]);
  assign timeout = count_q == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
  assign issue = state_q == ISSUE;
  assign fail = (state_q == IDLE && start && illegal) || (issue && !mem_ack && timeout);
  memory_bus_bridge_load_formatter u_fmt (
    .rdata(rdata_q),
    .offset(addr_q[1:0]),
    .option(opt_q),
    .data(fmt)
  );
  always_comb begin
    state_d = state_q;
    mem_req = issue;
    mem_we = issue & we_q;
    mem_addr = issue ? {addr_q[31:2], 2'b00} : '0;
    mem_wstrb = !(issue && we_q) ? 4'b0000 :
                opt_q == OPT_B ? 4'b0001 << addr_q[1:0] :
                opt_q == OPT_H ? 4'b0011 << addr_q[1:0] : 4'b1111;
    mem_wdata = !issue ? '0 :
                opt_q == OPT_B ? {4{data_q[7:0]}} :
                opt_q == OPT_H ? {2{data_q[15:0]}} : data_q;
    core_response = state_q == RESPOND;
    core_read_data = (core_response && !we_q && !err_q) ? fmt : '0;
    if (state_q == IDLE && start) state_d = illegal ? RESPOND : ISSUE;
    else if (issue && (mem_ack || timeout)) state_d = RESPOND;
    else if (state_q == RESPOND) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      opt_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      bus_error <= 1'b0;
      error_address <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        addr_q <= core_address;
        opt_q <= core_option;
        data_q <= core_write_data;
        we_q <= core_write;
        err_q <= illegal;
        count_q <= '0;
      end
      if (issue) begin
        count_q <= count_q + 1'b1;
        if (mem_ack) rdata_q <= mem_rdata;
        else if (timeout) err_q <= 1'b1;
      end
      if (fail) begin
        bus_error <= 1'b1;
        if (!bus_error) error_address <= issue ? addr_q : core_address;
      end
    end
  end
endmodule
